// File: rtl/uart_pkg.sv
// uart_pkg -- constants shared by the UART receiver and transmitter.
//   UART_DEFAULT_CLKS_PER_BIT : 115200 baud from a 100 MHz clock
//   RX_* / TX_*               : character FSM state encodings
//   cnt_width()               : counter width helper, never below 1 bit
package uart_pkg;

   localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- single-character UART receiver.
//   clk, reset_n : clock, async active-low reset
//   rx           : raw UART line (idle high, asynchronous)
//   byte_out     : last character received with a good stop bit
//   byte_valid   : one-cycle pulse when byte_out updates
//   char_good    : combinational strobe in the cycle a good stop bit is sampled
//   char_bad     : combinational strobe in the cycle a bad stop bit is sampled
//   char_data    : assembled character, valid alongside char_good
//   start_edge   : falling edge of synchronized rx accepted while IDLE
//   busy         : character FSM is not in IDLE
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | timing to mid start bit, rejects glitches
// RX_DATA  | sampling DBITS data bits, LSB first
// RX_STOP  | sampling the stop bit, reporting good/bad character
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int DBITS        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx,
   output logic [DBITS-1:0] byte_out,
   output logic             byte_valid,
   output logic             char_good,
   output logic             char_bad,
   output logic [DBITS-1:0] char_data,
   output logic             start_edge,
   output logic             busy
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int BW = cnt_width(DBITS + 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

   logic             sync1_q, sync2_q, rx_prev_q;
   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DBITS-1:0] shreg_q, shreg_d;
   logic [DBITS-1:0] byte_out_q, byte_out_d;
   logic             byte_valid_q, byte_valid_d;
   logic             rx_s, tick;

   assign rx_s       = sync2_q;
   assign tick       = (cnt_q == '0);
   assign start_edge = (state_q == RX_IDLE) && rx_prev_q && !rx_s;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      char_good    = 1'b0;
      char_bad     = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (start_edge) begin
               state_d   = RX_START;
               cnt_d     = HALF_LOAD;
               bit_cnt_d = '0;
            end
         end
         RX_START: begin
            if (tick) begin
               if (!rx_s) begin
                  state_d = RX_DATA;
                  cnt_d   = FULL_LOAD;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (tick) begin
               shreg_d   = {rx_s, shreg_q[DBITS-1:1]};
               cnt_d     = FULL_LOAD;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (tick) begin
               state_d = RX_IDLE;
               if (rx_s) begin
                  byte_out_d   = shreg_q;
                  byte_valid_d = 1'b1;
                  char_good    = 1'b1;
               end else begin
                  char_bad = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Synchronizer and edge-detect history preset high so release never sees an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
      end else begin
         sync1_q      <= rx;
         sync2_q      <= sync1_q;
         rx_prev_q    <= sync2_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign char_data  = shreg_q;
   assign busy       = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- assembles fixed-length frames of UART characters.
//   clk, reset_n : clock, async active-low reset
//   rx           : raw UART line
//   byte_out     : last good character; byte_valid pulses on update
//   frame_out    : last complete frame, first character in the top bits;
//                  frame_valid pulses with the last character's byte_valid
//   frame_err    : pulse on a stop-bit error or an inter-character timeout
//   busy         : character FSM is not idle
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int DBITS        = 8,
   parameter int FRAME_BYTES  = 18,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         rx,
   output logic [DBITS-1:0]             byte_out,
   output logic                         byte_valid,
   output logic [FRAME_BYTES*DBITS-1:0] frame_out,
   output logic                         frame_valid,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int FW = FRAME_BYTES * DBITS;
   localparam int AW = FW - DBITS;
   localparam int IW = cnt_width(FRAME_BYTES);
   localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO - 1);

   logic             char_good, char_bad, start_edge, rx_busy;
   logic [DBITS-1:0] char_data;

   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] asm_q, asm_d;
   logic [FW-1:0] frame_out_q, frame_out_d;
   logic          frame_valid_q, frame_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DBITS        (DBITS)
   ) u_rx_byte (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .char_good  (char_good),
      .char_bad   (char_bad),
      .char_data  (char_data),
      .start_edge (start_edge),
      .busy       (rx_busy)
   );

   always_comb begin
      idx_d         = idx_q;
      asm_d         = asm_q;
      frame_out_d   = frame_out_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      idle_cnt_d    = idle_cnt_q;

      // asm holds the first FRAME_BYTES-1 characters; the last one is
      // concatenated straight from the receiver so frame_valid lines up with byte_valid.
      if (char_good) begin
         asm_d = {asm_q[AW-DBITS-1:0], char_data};
         if (idx_q == IDX_LAST) begin
            frame_out_d   = {asm_q, char_data};
            frame_valid_d = 1'b1;
            idx_d         = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (char_bad) begin
         frame_err_d = 1'b1;
         idx_d       = '0;
      end

      // A start edge clears the counter first, so it beats a coincident timeout.
      if (start_edge || rx_busy || idx_q == '0) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == TO_LAST) begin
         idle_cnt_d  = '0;
         frame_err_d = 1'b1;
         idx_d       = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q         <= '0;
         asm_q         <= '0;
         frame_out_q   <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         idle_cnt_q    <= '0;
      end else begin
         idx_q         <= idx_d;
         asm_q         <= asm_d;
         frame_out_q   <= frame_out_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         idle_cnt_q    <= idle_cnt_d;
      end
   end

   assign frame_out   = frame_out_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = rx_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx -- scoreboard bench for uart_frame_rx (16 clocks per bit).
module tb_uart_frame_rx;

   localparam int CPB = 16;
   localparam int TOB = 20;
   localparam int NB  = 18;
   localparam int FW  = NB * 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rx = 1'b1;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic [FW-1:0] frame_out;
   logic          frame_valid;
   logic          frame_err;
   logic          busy;

   uart_frame_rx #(
      .CLKS_PER_BIT (CPB),
      .DBITS        (8),
      .FRAME_BYTES  (NB),
      .TIMEOUT_BITS (TOB)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx          (rx),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard and reference frame model
   logic [7:0]    byte_q[$];
   logic [FW-1:0] frame_q[$];
   logic [FW-1:0] m_frame = '0;
   int m_idx  = 0;
   int bv_exp = 0, fv_exp = 0, fe_exp = 0;
   int bv_seen = 0, fv_seen = 0, fe_seen = 0;

   always @(negedge clk) begin
      if (byte_valid) begin
         bv_seen++;
         check("byte_q_nonempty", FW'(byte_q.size() != 0), FW'(1));
         if (byte_q.size() != 0) check("byte_out", FW'(byte_out), FW'(byte_q.pop_front()));
      end
      if (frame_valid) begin
         fv_seen++;
         check("fv_with_bv", FW'(byte_valid), FW'(1));
         check("frame_q_nonempty", FW'(frame_q.size() != 0), FW'(1));
         if (frame_q.size() != 0) check("frame_out", frame_out, frame_q.pop_front());
      end
      if (frame_err) fe_seen++;
   end

   task automatic model_good(input logic [7:0] b);
      byte_q.push_back(b);
      bv_exp++;
      m_frame = {m_frame[FW-9:0], b};
      m_idx++;
      if (m_idx == NB) begin
         frame_q.push_back(m_frame);
         fv_exp++;
         m_idx = 0;
      end
   endtask

   task automatic model_drop();
      fe_exp++;
      m_idx = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      if (stop) model_good(b);
      else model_drop();
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop;
      idle(CPB);
      rx = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_out"}, FW'(byte_out), '0);
      check({tag, "_frame_out"}, frame_out, '0);
      check({tag, "_byte_valid"}, FW'(byte_valid), '0);
      check({tag, "_frame_valid"}, FW'(frame_valid), '0);
      check({tag, "_frame_err"}, FW'(frame_err), '0);
      check({tag, "_busy"}, FW'(busy), '0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_bv_count"}, FW'(bv_seen), FW'(bv_exp));
      check({tag, "_fv_count"}, FW'(fv_seen), FW'(fv_exp));
      check({tag, "_fe_count"}, FW'(fe_seen), FW'(fe_exp));
   endtask

   logic [7:0]    msg [NB] = '{8'h7b, 8'h68, 8'h69, 8'h5f, 8'h69, 8'h27, 8'h6d, 8'h5f, 8'h79,
                               8'h6f, 8'h75, 8'h72, 8'h5f, 8'h61, 8'h72, 8'h6d, 8'h79, 8'h7d};
   logic [FW-1:0] msg_frame = 144'h7b68695f69276d5f796f75725f61726d797d;
   logic [FW-1:0] frame_a;
   logic [7:0]    b;
   int            fv_before;

   initial begin
      idle(5);
      check_all_zero("reset");
      reset_n = 1'b1;
      idle(10);
      check("release_busy", FW'(busy), '0);

      // known 18-character frame, back-to-back
      for (int i = 0; i < NB; i++) send_byte(msg[i], 1'b1);
      idle(2 * CPB);
      check_counts("msg");
      check("msg_frame", frame_out, msg_frame);

      // bad stop bit
      send_byte(8'h41, 1'b0);
      idle(2 * CPB);
      check_counts("badstop");
      check("badstop_byte_out", FW'(byte_out), FW'(8'h7d));

      // 6-cycle glitch
      rx = 1'b0;
      idle(4);
      check("glitch_busy_seen", FW'(busy), FW'(1));
      idle(2);
      rx = 1'b1;
      idle(2 * CPB);
      check("glitch_busy_idle", FW'(busy), '0);
      check_counts("glitch");

      // partial frame then timeout
      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle(TOB * CPB);
      if (m_idx != 0) model_drop();
      check_counts("timeout");
      for (int i = 0; i < NB; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle(2 * CPB);
      check_counts("after_timeout");

      // two frames back-to-back, frame_out must hold across the second
      frame_a = '0;
      for (int i = 0; i < NB; i++) begin
         b = 8'($urandom_range(0, 255));
         frame_a = {frame_a[FW-9:0], b};
         send_byte(b, 1'b1);
      end
      for (int i = 0; i < NB; i++) begin
         if (i == 5) check("hold_frame", frame_out, frame_a);
         send_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      idle(2 * CPB);
      check_counts("two_frames");

      // reset during the data bits of character 10
      for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(i & 1);
         idle(CPB);
      end
      reset_n = 1'b0;
      idle(3);
      check_all_zero("midreset");
      m_idx = 0;
      rx = 1'b1;
      reset_n = 1'b1;
      fv_before = fv_seen;
      idle(3 * CPB);
      check("midreset_no_fv", FW'(fv_seen), FW'(fv_before));
      check_counts("midreset_release");
      for (int i = 0; i < NB; i++) begin
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         if (i == NB - 2) check("midreset_partial_no_fv", FW'(fv_seen), FW'(fv_before));
      end
      idle(2 * CPB);
      check_counts("midreset_frame");

      check("byte_q_drained", FW'(byte_q.size()), '0);
      check("frame_q_drained", FW'(frame_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
